glitch_filter_bank: RTL

GLITCH_FILTER_BANK -- requirements
Module: glitch_filter_bank

---
 rtl/glitch_filter_bank_pkg.sv | 20 ++
 rtl/glitch_filter_channel.sv | 83 ++++++++
 rtl/glitch_filter_bank.sv | 38 +++
 3 files changed

// File: rtl/glitch_filter_bank_pkg.sv
// Shared defaults and legal ranges for the glitch filter bank.
package glitch_filter_bank_pkg;

    // Channel count
    localparam int DefN           = 4;
    localparam int MinN           = 1;
    localparam int MaxN           = 32;

    // Stability counter / threshold width
    localparam int DefCountWidth  = 14;

    // Synchroniser depth
    localparam int DefSyncStages  = 2;
    localparam int MinSyncStages  = 2;
    localparam int MaxSyncStages  = 4;

    // Idle level of every channel
    localparam logic DefResetValue = 1'b0;

endpackage : glitch_filter_bank_pkg

// File: rtl/glitch_filter_channel.sv
// One debounce channel: synchroniser, previous-sample register, stability
// counter and registered filtered level with edge / glitch pulses.
module glitch_filter_channel
    import glitch_filter_bank_pkg::*;
#(
    parameter int   CountWidth = DefCountWidth,
    parameter int   SyncStages = DefSyncStages,
    parameter logic ResetValue = DefResetValue
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_async,
    input  logic [CountWidth-1:0] threshold,
    output logic                  filt_out,
    output logic                  rise,
    output logic                  fall,
    output logic                  glitch
);

    logic [SyncStages-1:0] sync_q, sync_d;
    logic                  p_q, p_d;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  out_q, out_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;
    logic                  glitch_q, glitch_d;

    logic                  sample_s;
    logic                  change_s;
    logic                  stable_s;

    assign sample_s = sync_q[SyncStages-1];
    assign change_s = (sample_s != p_q);
    assign stable_s = (count_q >= threshold);

    // Next-state logic: a change always restarts the count and blocks acceptance.
    always_comb begin
        sync_d   = {sync_q[SyncStages-2:0], in_async};
        p_d      = sample_s;
        count_d  = count_q;
        out_d    = out_q;
        glitch_d = 1'b0;
        if (change_s) begin
            count_d  = {CountWidth{1'b0}};
            // The sample moved away from a level that was never accepted.
            glitch_d = (p_q != out_q);
        end else if (stable_s) begin
            out_d    = p_q;
        end else begin
            // count_q < threshold here, so the increment can never wrap.
            count_d  = count_q + CountWidth'(1);
        end
        rise_d = out_d & ~out_q;
        fall_d = ~out_d & out_q;
    end

    // State and output registers; reset clears any filter in progress at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= {SyncStages{ResetValue}};
            p_q      <= ResetValue;
            count_q  <= {CountWidth{1'b0}};
            out_q    <= ResetValue;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            p_q      <= p_d;
            count_q  <= count_d;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
        end
    end

    assign filt_out = out_q;
    assign rise     = rise_q;
    assign fall     = fall_q;
    assign glitch   = glitch_q;

endmodule : glitch_filter_channel

// File: rtl/glitch_filter_bank.sv
// Bank of N independent glitch filters sharing one clock, reset and threshold.
// Every output comes straight from a channel flop.
module glitch_filter_bank
    import glitch_filter_bank_pkg::*;
#(
    parameter int   N          = DefN,
    parameter int   CountWidth = DefCountWidth,
    parameter int   SyncStages = DefSyncStages,
    parameter logic ResetValue = DefResetValue
) (
    input  logic                  Clk,
    input  logic                  nReset,
    input  logic [N-1:0]          Input,
    input  logic [CountWidth-1:0] Threshold,
    output logic [N-1:0]          Output,
    output logic [N-1:0]          Rise,
    output logic [N-1:0]          Fall,
    output logic [N-1:0]          Glitch
);

    for (genvar i = 0; i < N; i++) begin : g_ch
        glitch_filter_channel #(
            .CountWidth (CountWidth),
            .SyncStages (SyncStages),
            .ResetValue (ResetValue)
        ) u_channel (
            .clk       (Clk),
            .rst_n     (nReset),
            .in_async  (Input[i]),
            .threshold (Threshold),
            .filt_out  (Output[i]),
            .rise      (Rise[i]),
            .fall      (Fall[i]),
            .glitch    (Glitch[i])
        );
    end

endmodule : glitch_filter_bank
